counter_ctrl: RTL
=================

Name: counter_ctrl

Overview:
- Sequencer for the interval counter datapath.
- Accepts commands over a valid/ready interface and drives the counter's 8-bit state code and 32-bit interval.
- Watches the returned count value and auto-halts the counter when a programmed limit is reached.
- Sits between the host/MMIO command source and the counter instance.

Parameters:
DEF_INTERVAL, 32'd1, interval value loaded at reset
CLEAR_CYCLES, 2, cycles the RESET code is held during a CLEAR (minimum 1)

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command this cycle
cmd_op  input  3  opcode: 0 NOP, 1 SET_INTERVAL, 2 SET_LIMIT, 3 START, 4 PAUSE, 5 RESUME, 6 CLEAR, 7 reserved
cmd_data  input  32  operand for SET_INTERVAL / SET_LIMIT
cnt_value  input  32  current counter output
state  output  8  counter state code: 8'd0 RESET, 8'd1 RUN, 8'd2 HALT
interval  output  32  counter interval
done  output  1  one-cycle pulse when the limit is reached
cmd_err  output  1  one-cycle pulse when an accepted command is illegal in the current state
busy  output  1  high in S_RUN

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low on resetn. All outputs are registered.
- Reset values: FSM = S_IDLE, state = 8'd0, interval = DEF_INTERVAL, limit = 0, clr_cnt = 0, done = 0, cmd_err = 0, busy = 0, cmd_ready = 1.
- Handshake: a command is accepted on a cycle with cmd_valid && cmd_ready, and takes effect in the FSM/registers at that edge. cmd_ready = 0 only in S_CLEAR. NOP is accepted with no effect.

FSM states and their state code:
- S_IDLE → RESET
- S_RUN → RUN
- S_HALT → HALT
- S_DONE → HALT
- S_CLEAR → RESET

Commands:
- SET_INTERVAL: legal in S_IDLE, S_HALT and S_DONE. Sets interval <= cmd_data; a value of 0 is stored as 1. In S_RUN it raises cmd_err and interval is unchanged.
- SET_LIMIT: legal in every state. Sets limit <= cmd_data; 0 means no limit.
- START: S_IDLE → S_RUN. Illegal elsewhere.
- PAUSE: S_RUN → S_HALT. Illegal elsewhere.
- RESUME: S_HALT → S_RUN. Illegal elsewhere.
- CLEAR: from any state except S_CLEAR → S_CLEAR with clr_cnt = CLEAR_CYCLES-1. S_CLEAR counts down and goes to S_IDLE when clr_cnt == 0. The RESET code is therefore held for exactly CLEAR_CYCLES cycles.
- Opcode 7: illegal in every state.
- Any illegal command is accepted, dropped, and pulses cmd_err high for one cycle starting the next cycle. The FSM is unchanged.

Limit detect:
- In S_RUN with limit != 0 and cnt_value >= limit (unsigned), go to S_DONE next edge and pulse done for one cycle.
- Because state is registered, the counter sees RUN for one more cycle. With interval == 1 it may therefore overshoot the limit by exactly 1; this is the specified behaviour.
- S_DONE is left only by CLEAR. SET_LIMIT or SET_INTERVAL in S_DONE does not restart the counter.

Priority within one cycle:
1. resetn.
2. Accepted CLEAR.
3. Limit detect.
4. Other commands.

If limit detect and a PAUSE/RESUME/START fire together, the FSM goes to S_DONE and the command raises cmd_err. SET_LIMIT in the same cycle as limit detect still updates limit, but detection that cycle uses the old limit.

Further rules:
- The limit is not re-checked in S_HALT. RESUME with cnt_value already >= limit goes to S_RUN, then to S_DONE on the next cycle.
- resetn asserted mid-operation forces all reset values immediately. Any in-flight clear is abandoned and the counter sees the RESET code.
- busy = (FSM == S_RUN).

Test Plan:
- Reset then idle: assert resetn low, release, run 5 cycles → state = 0, interval = 1, cmd_ready = 1, done = cmd_err = 0.
- Basic run:
  - Stimulus: SET_INTERVAL 4, SET_LIMIT 3, START; counter model attached.
  - Required: state = 1 the cycle after START; counter reaches 3 about 12 cycles later; next edge state = 2 and done pulses exactly once; cnt_value stays 3.
- Pause/resume: interval 2, no limit, START, PAUSE after count = 5, wait 10 cycles, RESUME → count frozen at 5 while state = 2, then resumes at 6.
- Illegal ops:
  - Stimulus: SET_INTERVAL during RUN; RESUME in S_IDLE; opcode 7.
  - Required: cmd_err pulses once for each; interval and FSM unchanged.
  - Stimulus: SET_INTERVAL 0 in S_IDLE. Required: interval = 1.
- Clear sequencing:
  - Stimulus: CLEAR from S_DONE with CLEAR_CYCLES = 2, cmd_valid held high with START.
  - Required: cmd_ready low for 2 cycles, state = 0 for 2 cycles; START accepted on the first ready cycle and counter restarts from 0.
- Collisions and async reset:
  - Stimulus: limit hit on the same cycle as PAUSE. Required: S_DONE, done = 1, cmd_err = 1.
  - Stimulus: CLEAR on the same cycle as limit hit. Required: S_CLEAR, no done.
  - Stimulus: resetn low mid-clock in S_RUN. Required: state = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/counter_ctrl.sv
// Command sequencer for the interval counter: accepts host commands, drives the
// counter's state code and interval, and auto-halts the counter at a programmed limit.
module counter_ctrl #(
    parameter logic [31:0] DEF_INTERVAL = 32'd1,
    parameter int          CLEAR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    // A command transfers on any rising edge where cmd_valid && cmd_ready; it
    // takes effect at that same edge. cmd_valid, cmd_op and cmd_data must be held
    // stable while cmd_valid is high and cmd_ready is low.
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cnt_value,
    output logic [7:0]  state,
    output logic [31:0] interval,
    output logic        done,
    output logic        cmd_err,
    output logic        busy,
    output logic [2:0]  dbg_fsm
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_HALT  = 3'd2,
        S_DONE  = 3'd3,
        S_CLEAR = 3'd4
    } fsm_t;

    localparam logic [2:0] OP_NOP          = 3'd0;
    localparam logic [2:0] OP_SET_INTERVAL = 3'd1;
    localparam logic [2:0] OP_SET_LIMIT    = 3'd2;
    localparam logic [2:0] OP_START        = 3'd3;
    localparam logic [2:0] OP_PAUSE        = 3'd4;
    localparam logic [2:0] OP_RESUME       = 3'd5;
    localparam logic [2:0] OP_CLEAR        = 3'd6;

    localparam logic [7:0] CODE_RESET = 8'd0;
    localparam logic [7:0] CODE_RUN   = 8'd1;
    localparam logic [7:0] CODE_HALT  = 8'd2;

    localparam int             CW       = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CW-1:0]  CLR_INIT = CW'(CLEAR_CYCLES - 1);

    fsm_t          fsm_q, fsm_d;
    logic [31:0]   limit_q, limit_d;
    logic [31:0]   interval_d;
    logic [CW-1:0] clr_q, clr_d;
    logic          err_d, done_d;
    logic [7:0]    state_d;
    logic          accept, limit_hit, clear_acc;

    assign dbg_fsm = fsm_q;

    always_comb begin
        fsm_d      = fsm_q;
        limit_d    = limit_q;
        interval_d = interval;
        clr_d      = clr_q;
        err_d      = 1'b0;
        done_d     = 1'b0;

        accept    = cmd_valid && cmd_ready;
        clear_acc = accept && (cmd_op == OP_CLEAR);
        // Detection always uses the limit held before this edge.
        limit_hit = (fsm_q == S_RUN) && (limit_q != 32'd0) && (cnt_value >= limit_q);

        if (fsm_q == S_CLEAR) begin
            if (clr_q == '0) fsm_d = S_IDLE;
            else             clr_d = clr_q - CW'(1);
        end

        if (accept) begin
            case (cmd_op)
                OP_NOP: ;
                OP_SET_INTERVAL: begin
                    if (fsm_q == S_RUN) err_d = 1'b1;
                    else interval_d = (cmd_data == 32'd0) ? 32'd1 : cmd_data;
                end
                OP_SET_LIMIT: limit_d = cmd_data;
                OP_START: begin
                    if (fsm_q == S_IDLE) fsm_d = S_RUN;
                    else                 err_d = 1'b1;
                end
                OP_PAUSE: begin
                    if (fsm_q == S_RUN && !limit_hit) fsm_d = S_HALT;
                    else                              err_d = 1'b1;
                end
                OP_RESUME: begin
                    if (fsm_q == S_HALT) fsm_d = S_RUN;
                    else                 err_d = 1'b1;
                end
                OP_CLEAR: begin
                    fsm_d = S_CLEAR;
                    clr_d = CLR_INIT;
                end
                default: err_d = 1'b1;
            endcase
        end

        if (limit_hit && !clear_acc) begin
            fsm_d  = S_DONE;
            done_d = 1'b1;
        end

        case (fsm_d)
            S_RUN:          state_d = CODE_RUN;
            S_HALT, S_DONE: state_d = CODE_HALT;
            default:        state_d = CODE_RESET;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with fsm_q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm_q     <= S_IDLE;
            limit_q   <= 32'd0;
            clr_q     <= '0;
            interval  <= DEF_INTERVAL;
            state     <= CODE_RESET;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            fsm_q     <= fsm_d;
            limit_q   <= limit_d;
            clr_q     <= clr_d;
            interval  <= interval_d;
            state     <= state_d;
            done      <= done_d;
            cmd_err   <= err_d;
            busy      <= (fsm_d == S_RUN);
            cmd_ready <= (fsm_d != S_CLEAR);
        end
    end

endmodule
